// File: rtl/fix_tag_value_parser.sv
// FIX receive front end: turns a raw "tag=value<SOH>" byte stream into registered
// tag/value strobes, flags malformed fields and resynchronises on the next SOH.
module fix_tag_value_parser #(
  parameter int          VALUE_WIDTH    = 128,
  parameter logic [7:0]  SOH_CHAR       = 8'h01,
  parameter int          MAX_TAG_DIGITS = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_valid_i,
  input  logic [7:0]             data_i,
  output logic                   tag_valid_o,
  output logic [31:0]            tag_o,
  output logic                   val_valid_o,
  output logic [VALUE_WIDTH-1:0] val_o,
  output logic                   start_of_message_o,
  output logic                   end_of_message_o,
  output logic                   error_o,
  output logic [2:0]             error_code_o
);

  localparam int MAX_CHARS = VALUE_WIDTH / 8;
  localparam int LEN_W     = $clog2(MAX_CHARS + 1);
  localparam int CNT_W     = $clog2(MAX_TAG_DIGITS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TAG_DIGITS);

  typedef enum logic [1:0] {ST_TAG, ST_VALUE, ST_RESYNC} state_t;

  state_t                 state_q;
  logic [31:0]            tagAcc_q;
  logic [CNT_W-1:0]       tagCnt_q;
  logic [VALUE_WIDTH-1:0] valReg_q;
  logic [LEN_W-1:0]       valLen_q;
  logic                   msgOpen_q;
  logic                   fieldIsTen_q;
  logic                   tagValid_q;
  logic [31:0]            tagOut_q;
  logic                   valValid_q;
  logic [VALUE_WIDTH-1:0] valOut_q;
  logic                   som_q;
  logic                   eom_q;
  logic                   errPulse_q;
  logic [2:0]             errCode_q;

  logic        isDigit, isEquals, isSoh;
  logic [31:0] tagAcc_d;
  logic        errFire_d;
  logic [2:0]  errCode_d;
  logic        errToTag_d;

  assign isDigit  = (data_i >= 8'h30) && (data_i <= 8'h39);
  assign isEquals = (data_i == 8'h3D);
  assign isSoh    = (data_i == SOH_CHAR);
  assign tagAcc_d = (tagAcc_q * 32'd10) + {28'd0, data_i[3:0]};

  // An SOH that is itself the offending byte already ends the field, so it skips RESYNC
  always_comb begin
    errFire_d  = 1'b0;
    errCode_d  = 3'd0;
    errToTag_d = 1'b0;
    if (data_valid_i) begin
      case (state_q)
        ST_TAG: begin
          if (isDigit && (tagCnt_q == MAX_CNT)) begin
            errFire_d = 1'b1;
            errCode_d = 3'd3;
          end else if (isEquals && (tagCnt_q == '0)) begin
            errFire_d = 1'b1;
            errCode_d = 3'd2;
          end else if (!isDigit && !isEquals) begin
            errFire_d  = 1'b1;
            errCode_d  = 3'd1;
            errToTag_d = isSoh;
          end
        end
        ST_VALUE: begin
          if (isSoh && (valLen_q == '0)) begin
            errFire_d  = 1'b1;
            errCode_d  = 3'd4;
            errToTag_d = 1'b1;
          end else if (!isSoh && (valLen_q == MAX_LEN)) begin
            errFire_d = 1'b1;
            errCode_d = 3'd5;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_TAG;
      tagAcc_q     <= '0;
      tagCnt_q     <= '0;
      valReg_q     <= '0;
      valLen_q     <= '0;
      msgOpen_q    <= 1'b0;
      fieldIsTen_q <= 1'b0;
      tagValid_q   <= 1'b0;
      tagOut_q     <= '0;
      valValid_q   <= 1'b0;
      valOut_q     <= '0;
      som_q        <= 1'b0;
      eom_q        <= 1'b0;
      errPulse_q   <= 1'b0;
      errCode_q    <= '0;
    end else begin
      tagValid_q <= 1'b0;
      valValid_q <= 1'b0;
      som_q      <= 1'b0;
      eom_q      <= 1'b0;
      errPulse_q <= 1'b0;
      if (errFire_d) begin
        errPulse_q <= 1'b1;
        errCode_q  <= errCode_d;
        msgOpen_q  <= 1'b0;
        tagAcc_q   <= '0;
        tagCnt_q   <= '0;
        valReg_q   <= '0;
        valLen_q   <= '0;
        state_q    <= errToTag_d ? ST_TAG : ST_RESYNC;
      end else if (data_valid_i) begin
        case (state_q)
          ST_TAG: begin
            if (isDigit) begin
              tagAcc_q <= tagAcc_d;
              tagCnt_q <= tagCnt_q + CNT_W'(1);
            end else begin
              tagValid_q   <= 1'b1;
              tagOut_q     <= tagAcc_q;
              som_q        <= !msgOpen_q;
              eom_q        <= (tagAcc_q == 32'd10);
              fieldIsTen_q <= (tagAcc_q == 32'd10);
              msgOpen_q    <= 1'b1;
              tagAcc_q     <= '0;
              tagCnt_q     <= '0;
              state_q      <= ST_VALUE;
            end
          end
          ST_VALUE: begin
            if (!isSoh) begin
              valReg_q <= {valReg_q[VALUE_WIDTH-9:0], data_i};
              valLen_q <= valLen_q + LEN_W'(1);
            end else begin
              valValid_q <= 1'b1;
              valOut_q   <= valReg_q;
              valReg_q   <= '0;
              valLen_q   <= '0;
              if (fieldIsTen_q) msgOpen_q <= 1'b0;
              state_q    <= ST_TAG;
            end
          end
          default: begin
            if (isSoh) state_q <= ST_TAG;
          end
        endcase
      end
    end
  end

  assign tag_valid_o        = tagValid_q;
  assign tag_o              = tagOut_q;
  assign val_valid_o        = valValid_q;
  assign val_o              = valOut_q;
  assign start_of_message_o = som_q;
  assign end_of_message_o   = eom_q;
  assign error_o            = errPulse_q;
  assign error_code_o       = errCode_q;

endmodule

// File: tb/tb_fix_tag_value_parser.sv
// Bench for fix_tag_value_parser: directed FIX streams plus random fields, all strobes
// checked in order against a string-level field model.
module tb_fix_tag_value_parser;

  localparam logic [7:0] SOH = 8'h7C;

  logic         clk;
  logic         rst;
  logic         data_valid_i;
  logic [7:0]   data_i;
  logic         tag_valid_o;
  logic [31:0]  tag_o;
  logic         val_valid_o;
  logic [127:0] val_o;
  logic         start_of_message_o;
  logic         end_of_message_o;
  logic         error_o;
  logic [2:0]   error_code_o;

  fix_tag_value_parser #(
    .VALUE_WIDTH(128),
    .SOH_CHAR(SOH),
    .MAX_TAG_DIGITS(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_valid_i(data_valid_i),
    .data_i(data_i),
    .tag_valid_o(tag_valid_o),
    .tag_o(tag_o),
    .val_valid_o(val_valid_o),
    .val_o(val_o),
    .start_of_message_o(start_of_message_o),
    .end_of_message_o(end_of_message_o),
    .error_o(error_o),
    .error_code_o(error_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  bit randIdle    = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected strobes: kind 0 = tag, 1 = value, 2 = error
  typedef struct {
    int           kind;
    logic [127:0] data;
    logic         som;
    logic         eom;
  } evt_t;
  evt_t expQ[$];

  // Field model: collects the raw characters of the current field and interprets them at the delimiter
  int  mode = 0;
  byte tagText[$];
  byte valText[$];
  bit  msgOpen = 1'b0;
  bit  lastTen = 1'b0;

  function automatic void pushEvt(int kind, logic [127:0] data, logic som, logic eom);
    evt_t e;
    e.kind = kind; e.data = data; e.som = som; e.eom = eom;
    expQ.push_back(e);
  endfunction

  function automatic void modelReset();
    mode = 0; msgOpen = 1'b0; lastTen = 1'b0;
    tagText.delete(); valText.delete();
  endfunction

  function automatic void modelError(int code, int nextMode);
    pushEvt(2, 128'(code), 1'b0, 1'b0);
    msgOpen = 1'b0;
    tagText.delete(); valText.delete();
    mode = nextMode;
  endfunction

  function automatic void modelByte(byte c);
    logic [31:0]  t;
    logic [127:0] v;
    bit digit;
    digit = (c >= 8'h30) && (c <= 8'h39);
    if (mode == 0) begin
      if (digit) begin
        if (tagText.size() == 9) modelError(3, 2);
        else tagText.push_back(c);
      end else if (c == 8'h3D) begin
        if (tagText.size() == 0) modelError(2, 2);
        else begin
          t = 0;
          foreach (tagText[i]) t = t * 10 + 32'(int'(tagText[i]) - 48);
          pushEvt(0, 128'(t), !msgOpen, t == 10);
          msgOpen = 1'b1;
          lastTen = (t == 10);
          tagText.delete();
          mode = 1;
        end
      end else modelError(1, (c == SOH) ? 0 : 2);
    end else if (mode == 1) begin
      if (c != SOH) begin
        if (valText.size() == 16) modelError(5, 2);
        else valText.push_back(c);
      end else if (valText.size() == 0) modelError(4, 0);
      else begin
        v = 0;
        foreach (valText[i]) v = (v << 8) | 128'(valText[i]);
        pushEvt(1, v, 1'b0, 1'b0);
        if (lastTen) msgOpen = 1'b0;
        valText.delete();
        mode = 0;
      end
    end else if (c == SOH) mode = 0;
  endfunction

  // Every strobe must be the next one the model predicted
  always @(negedge clk) begin
    evt_t e;
    int   obsKind;
    if (!rst) begin
      if (tag_valid_o && val_valid_o) checkOutput("bothStrobes", 1, 0);
      if (tag_valid_o || val_valid_o || error_o) begin
        obsKind = tag_valid_o ? 0 : (val_valid_o ? 1 : 2);
        if (expQ.size() == 0) checkOutput("unexpectedStrobe", 128'(obsKind + 1), 0);
        else begin
          e = expQ.pop_front();
          checkOutput("strobeKind", 128'(obsKind), 128'(e.kind));
          if (e.kind == 0) begin
            checkOutput("tag", 128'(tag_o), e.data);
            checkOutput("somEom", {126'd0, start_of_message_o, end_of_message_o}, {126'd0, e.som, e.eom});
          end else if (e.kind == 1) checkOutput("value", val_o, e.data);
          else checkOutput("errCode", 128'(error_code_o), e.data);
        end
      end
    end
  end

  task automatic applyByte(input byte c);
    if (randIdle) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    data_valid_i = 1'b1;
    data_i       = c;
    modelByte(c);
    @(posedge clk);
    #1;
    data_valid_i = 1'b0;
    data_i       = 8'h00;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) applyByte(s[i]);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic randomField();
    int  r, n;
    byte c;
    r = $urandom_range(0, 19);
    if (r == 1) n = 10;
    else if (r == 0) n = 0;
    else n = $urandom_range(1, 9);
    if (r == 2) begin
      applyByte(8'h31); applyByte(8'h30);
    end else for (int i = 0; i < n; i++) applyByte(8'($urandom_range(48, 57)));
    if (r == 3) applyByte(8'h58);
    applyByte(8'h3D);
    n = (r == 4) ? 0 : ((r == 5) ? 17 : $urandom_range(1, 16));
    for (int i = 0; i < n; i++) begin
      do c = 8'($urandom_range(32, 126)); while (c == SOH);
      applyByte(c);
    end
    applyByte(SOH);
  endtask

  initial begin
    rst = 1'b1;
    data_valid_i = 1'b0;
    data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetStrobes", {123'd0, tag_valid_o, val_valid_o, start_of_message_o, end_of_message_o, error_o}, 0);
    checkOutput("resetTag", 128'(tag_o), 0);
    checkOutput("resetVal", val_o, 0);
    checkOutput("resetErrCode", 128'(error_code_o), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("8=FIX.4.3|9=5|35=A|10=123|");
    checkOutput("stream1TagHeld", 128'(tag_o), 10);
    checkOutput("stream1ValHeld", val_o, 128'h313233);

    applyStimulus("8=FIX.4.3|9=5|35=A|10=123|8=FIX.4.3|9=5|35=A|10=123|");

    applyStimulus("3X=1|34=7|");
    checkOutput("errCodeHeld1", 128'(error_code_o), 1);
    checkOutput("afterErr1Val", val_o, 128'h37);
    applyStimulus("=5|");
    checkOutput("errCodeHeld2", 128'(error_code_o), 2);
    applyStimulus("1234567890=1|");
    checkOutput("errCodeHeld3", 128'(error_code_o), 3);
    applyStimulus("58=|");
    checkOutput("errCodeHeld4", 128'(error_code_o), 4);
    applyStimulus("58=ABCDEFGHIJKLMNOPQ|9=Z|");
    checkOutput("errCodeHeld5", 128'(error_code_o), 5);
    checkOutput("afterErr5Val", val_o, 128'h5A);

    randIdle = 1'b1;
    applyStimulus("8=FIX.4.3|9=5|35=A|10=123|");
    randIdle = 1'b0;
    checkOutput("gappedTagHeld", 128'(tag_o), 10);

    applyStimulus("8=FIX");
    checkOutput("pendingBeforeReset", 128'(expQ.size()), 0);
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("8=A|10=1|");
    checkOutput("afterResetVal", val_o, 128'h31);

    for (int f = 0; f < 60; f++) begin
      randIdle = ($urandom_range(0, 1) == 1);
      randomField();
    end
    randIdle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pendingEvents", 128'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
